frame_bank_sched: RTL and testbench

FRAME_BANK_SCHED -- requirements
Module: frame_bank_sched

---
 rtl/frame_bank_sched_pkg.sv | 13 +
 rtl/frame_bank_sched_if.sv | 27 ++
 rtl/frame_bank_sched_addr_cnt.sv | 28 ++
 rtl/frame_bank_sched.sv | 106 ++++++++++
 tb/tb_frame_bank_sched.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/frame_bank_sched_pkg.sv
// frame_pkg: shared FSM state type and default geometry for the frame bank scheduler.
package frame_pkg;

    localparam int ADDR_W_DEF      = 13;
    localparam int FRAME_WORDS_DEF = 8192;

    typedef enum logic [1:0] {
        WAIT_SOF,
        WRITE,
        SWAP
    } state_t;

endpackage

// File: rtl/frame_bank_sched_if.sv
// frame_bank_sched_if: pixel-in, BRAM-write and reader-handshake signals of the frame bank scheduler.
interface frame_bank_sched_if #(
    parameter int ADDR_W = frame_pkg::ADDR_W_DEF
);

    logic              sof;
    logic              tvalid;
    logic              write_enable;
    logic [ADDR_W-1:0] bram_addr_in;
    logic              wr_bank;
    logic              rd_start;
    logic              rd_done;
    logic              rd_bank;
    logic              frame_avail;
    logic [7:0]        drop_cnt;

    modport master (
        output sof, tvalid, rd_start, rd_done,
        input  write_enable, bram_addr_in, wr_bank, rd_bank, frame_avail, drop_cnt
    );

    modport slave (
        input  sof, tvalid, rd_start, rd_done,
        output write_enable, bram_addr_in, wr_bank, rd_bank, frame_avail, drop_cnt
    );

endinterface

// File: rtl/frame_bank_sched_addr_cnt.sv
// frame_addr_cnt: per-frame word index; clear and advance in one cycle yield index 1.
module frame_addr_cnt #(
    parameter int ADDR_W      = frame_pkg::ADDR_W_DEF,
    parameter int FRAME_WORDS = frame_pkg::FRAME_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] idx,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

    logic [ADDR_W-1:0] base;

    assign base = clr ? '0 : idx;
    assign tc   = idx == LAST;

    always_ff @(posedge clk) begin
        if (reset)
            idx <= '0;
        else
            idx <= adv ? ((base == LAST) ? '0 : base + ADDR_W'(1)) : base;
    end

endmodule

// File: rtl/frame_bank_sched.sv
// frame_bank_sched: ping-pong frame writer with a single reader and drop accounting.
// Define BLACKOUT_EN to suppress BRAM writes for the first BLACKOUT_WORDS words of each frame.
module frame_bank_sched
    import frame_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int FRAME_WORDS    = FRAME_WORDS_DEF,
    parameter int BLACKOUT_WORDS = 640
) (
    input  logic               clk,
    input  logic               reset,
    frame_bank_sched_if.slave  bus
);

`ifdef BLACKOUT_EN
    localparam int unsigned BLANK_WORDS = BLACKOUT_WORDS;
`else
    localparam int unsigned BLANK_WORDS = 0;
`endif

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx;
    logic              tc, clr, adv, beat, abort, swap;
    logic              claim, busy_eff, keep, busy, wr_bank, rd_bank, frame_avail;
    logic [7:0]        drop_cnt;

    frame_addr_cnt #(.ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .adv   (adv),
        .idx   (idx),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= WAIT_SOF;
        else
            state <= state_n;
    end

    // A sof beat inside a frame restarts it: clr+adv writes address 0 and leaves index 1.
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        adv     = 1'b0;
        beat    = 1'b0;
        abort   = 1'b0;
        swap    = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (bus.tvalid && bus.sof) begin
                    clr     = 1'b1;
                    adv     = 1'b1;
                    beat    = 1'b1;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (bus.tvalid) begin
                    beat    = 1'b1;
                    adv     = 1'b1;
                    abort   = bus.sof && idx != '0;
                    clr     = abort;
                    state_n = (tc && !abort) ? SWAP : WRITE;
                end
            end
            SWAP: begin
                swap    = 1'b1;
                clr     = 1'b1;
                state_n = WAIT_SOF;
            end
            default: state_n = WAIT_SOF;
        endcase
    end

    // A claim in the SWAP cycle wins, so the new frame sees a busy reader and is dropped.
    assign claim    = bus.rd_start && frame_avail;
    assign busy_eff = busy || claim;
    assign keep     = swap && busy_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            frame_avail <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            busy        <= claim ? 1'b1 : (bus.rd_done ? 1'b0 : busy);
            rd_bank     <= claim ? !wr_bank : rd_bank;
            wr_bank     <= (swap && !busy_eff) ? !wr_bank : wr_bank;
            frame_avail <= claim ? 1'b0 : ((swap && !busy_eff) ? 1'b1 : frame_avail);
            drop_cnt    <= ((abort || keep) && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
        end
    end

    assign bus.bram_addr_in = abort ? '0 : idx;
    assign bus.write_enable = beat && (32'(bus.bram_addr_in) >= BLANK_WORDS);
    assign bus.wr_bank      = wr_bank;
    assign bus.rd_bank      = rd_bank;
    assign bus.frame_avail  = frame_avail;
    assign bus.drop_cnt     = drop_cnt;

endmodule

// File: tb/tb_frame_bank_sched.sv
// tb_frame_bank_sched: directed self-checking bench for frame_bank_sched at default geometry.
module tb_frame_bank_sched;
    import frame_pkg::*;

    localparam int FW = FRAME_WORDS_DEF;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    frame_bank_sched_if #(.ADDR_W(ADDR_W_DEF)) bus ();

    frame_bank_sched #(
        .ADDR_W         (ADDR_W_DEF),
        .FRAME_WORDS    (FW),
        .BLACKOUT_WORDS (640)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ewe(input int i);
`ifdef BLACKOUT_EN
        return (i >= 640) ? 1 : 0;
`else
        return (i >= 0) ? 1 : 0;
`endif
    endfunction

    // Drive one cycle of inputs after the edge; outputs are sampled at the following negedge.
    task automatic apply(input logic s, input logic v, input logic rs, input logic rd);
        @(posedge clk);
        #1;
        bus.sof      = s;
        bus.tvalid   = v;
        bus.rd_start = rs;
        bus.rd_done  = rd;
        @(negedge clk);
    endtask

    task automatic status(input string tag, input int wb, input int rb, input int fa, input int dc);
        check({tag, "_wr_bank"}, int'(bus.wr_bank), wb);
        check({tag, "_rd_bank"}, int'(bus.rd_bank), rb);
        check({tag, "_frame_avail"}, int'(bus.frame_avail), fa);
        check({tag, "_drop_cnt"}, int'(bus.drop_cnt), dc);
    endtask

    task automatic send_frame(input bit full, input int bank);
        for (int i = 0; i < FW; i++) begin
            apply(i == 0, 1'b1, 1'b0, 1'b0);
            if (full || i == 0 || i == FW - 1) begin
                check("beat_addr", int'(bus.bram_addr_in), i);
                check("beat_we", int'(bus.write_enable), ewe(i));
                check("beat_bank", int'(bus.wr_bank), bank);
            end
        end
    endtask

    initial begin
        bus.sof = 1'b0; bus.tvalid = 1'b0; bus.rd_start = 1'b0; bus.rd_done = 1'b0;
        repeat (2) apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("reset", 0, 1, 0, 0);
        check("reset_we", int'(bus.write_enable), 0);
        check("reset_addr", int'(bus.bram_addr_in), 0);
        reset = 1'b0;
        // first frame, every beat checked, then SWAP
        send_frame(1'b1, 0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        check("swap_we", int'(bus.write_enable), 0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("f1", 1, 1, 1, 0);
        // reader claims bank 0; a second rd_start with nothing available is ignored
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("claim", 1, 0, 0, 0);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("claim_idle", 1, 0, 0, 0);
        // second frame completes while reader busy: bank kept, frame dropped
        send_frame(1'b0, 1);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("busy_swap", 1, 0, 0, 1);
        // release reader; third frame swaps normally
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 1);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("f3", 0, 0, 1, 1);
        // stalled stream: address advances only on valid beats
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        check("stall_sof_addr", int'(bus.bram_addr_in), 0);
        for (int j = 1; j < 100; j++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            check("stall_addr", int'(bus.bram_addr_in), j);
            check("stall_we_on", int'(bus.write_enable), ewe(j));
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            check("stall_we_off", int'(bus.write_enable), 0);
        end
        // sof at index 100 aborts and restarts at address 0 in the same bank
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_addr", int'(bus.bram_addr_in), 0);
        check("abort_we", int'(bus.write_enable), ewe(0));
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("abort", 0, 0, 1, 2);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        check("abort_next_addr", int'(bus.bram_addr_in), 1);
        for (int j = 2; j < 4000; j++) apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_addr", int'(bus.bram_addr_in), 4000);
        // reset mid-frame discards the frame without counting a drop
        reset = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("midreset", 0, 1, 0, 0);
        check("midreset_we", int'(bus.write_enable), 0);
        check("midreset_addr", int'(bus.bram_addr_in), 0);
        reset = 1'b0;
        // rd_start in the SWAP cycle: reader takes the old bank, new frame dropped
        send_frame(1'b0, 0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("fa", 1, 1, 1, 0);
        send_frame(1'b0, 1);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        check("swap_claim_we", int'(bus.write_enable), 0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        status("swap_claim", 1, 0, 0, 1);
        // back-to-back sof beats each abort; counter saturates at 255
        for (int n = 1; n <= 300; n++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0);
            if (n == 255) check("sat_254", int'(bus.drop_cnt), 254);
            if (n == 256) check("sat_255", int'(bus.drop_cnt), 255);
        end
        check("sat_addr", int'(bus.bram_addr_in), 0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_hold", int'(bus.drop_cnt), 255);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
